// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch unit
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_VALID, S_DRAIN, S_TRAP} fetch_state_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: architectural PC register with redirect load and sequential increment
// Ports: clk, rst (async, active-high); i_load/i_load_pc load a redirect target;
//        i_inc advances by one instruction; o_pc current PC; o_pc_plus4 next sequential PC.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_load_pc,
  input  logic                  i_inc,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4
);
  logic [ADDR_WIDTH-1:0] r_pc;
  // Increment wraps modulo 2^ADDR_WIDTH by construction.
  assign o_pc_plus4 = r_pc + ADDR_WIDTH'(INSTR_BYTES);
  assign o_pc = r_pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pc <= RESET_VECTOR;
    else r_pc <= i_load ? i_load_pc : i_inc ? o_pc_plus4 : r_pc;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instructions at the PC over req/ack and hands them to decode via valid/ready
// Ports: clk, rst (async, active-high); redirect_valid/redirect_pc branch target;
//        imem_req/imem_addr/imem_ack/imem_rdata memory port (one request outstanding);
//        instr_valid/instr_ready/instr/instr_pc decode handshake.
// Option INSTR_FETCH_MISALIGN_TRAP_EN: adds fetch_misaligned and a terminal trap state
// for redirects to non-word-aligned targets instead of silently clearing the low bits.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_misaligned
`endif
);
  fetch_state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_req_addr, w_req_next, w_pc, w_pc_plus4, w_redir_pc;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic w_pc_load, w_pc_inc, w_req_load, w_latch, w_misal, w_trap_pend;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  logic r_misal;
  assign w_redir_pc = redirect_pc;
  assign w_misal = redirect_valid && (redirect_pc[1:0] != 2'b00);
  // A misaligned redirect seen during a drain is remembered until the ack retires it.
  assign w_trap_pend = r_misal | w_misal;
  assign fetch_misaligned = r_misal;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_misal <= 1'b0;
    else if (r_state != S_TRAP) r_misal <= w_trap_pend;
`else
  assign w_redir_pc = redirect_pc & ~ADDR_WIDTH'(3);
  assign w_misal = 1'b0;
  assign w_trap_pend = 1'b0;
`endif
  fetch_pc_reg #(.ADDR_WIDTH(ADDR_WIDTH), .RESET_VECTOR(RESET_VECTOR)) u_pc (
    .clk(clk), .rst(rst), .i_load(w_pc_load), .i_load_pc(w_redir_pc),
    .i_inc(w_pc_inc), .o_pc(w_pc), .o_pc_plus4(w_pc_plus4)
  );
  assign imem_req = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign imem_addr = r_req_addr;
  assign instr_valid = (r_state == S_VALID);
  assign instr = r_instr;
  assign instr_pc = r_instr_pc;
  // req_addr always tracks pc whenever a new request starts, so the new request
  // address is either the redirect target or the already-updated pc.
  always_comb begin
    w_next = r_state;
    w_pc_load = 1'b0;
    w_pc_inc = 1'b0;
    w_req_load = 1'b0;
    w_req_next = redirect_valid ? w_redir_pc : w_pc;
    w_latch = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_pc_load = redirect_valid;
        w_req_load = 1'b1;
        w_next = w_misal ? S_TRAP : S_FETCH;
      end
      S_FETCH:
        if (imem_ack && !redirect_valid) begin
          w_latch = 1'b1;
          w_pc_inc = 1'b1;
          w_next = S_VALID;
        end else if (imem_ack) begin
          w_pc_load = 1'b1;
          w_req_load = 1'b1;
          w_next = w_misal ? S_TRAP : S_FETCH;
        end else if (redirect_valid) begin
          w_pc_load = 1'b1;
          w_next = S_DRAIN;
        end
      S_DRAIN: begin
        w_pc_load = redirect_valid;
        w_req_load = imem_ack;
        w_next = !imem_ack ? S_DRAIN : w_trap_pend ? S_TRAP : S_FETCH;
      end
      S_VALID:
        if (redirect_valid) begin
          w_pc_load = 1'b1;
          w_req_load = 1'b1;
          w_next = w_misal ? S_TRAP : S_FETCH;
        end else if (instr_ready) begin
          w_req_load = 1'b1;
          w_next = S_FETCH;
        end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_req_addr <= RESET_VECTOR;
      r_instr <= DATA_WIDTH'(NOP_INSTR);
      r_instr_pc <= '0;
    end else begin
      r_state <= w_next;
      if (w_req_load) r_req_addr <= w_req_next;
      if (w_latch) begin
        r_instr <= imem_rdata;
        r_instr_pc <= r_req_addr;
      end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ack = 1'b1;
  logic [31:0] imem_rdata;
  logic instr_valid;
  logic instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  int n_vec = 0;
  int n_err = 0;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  logic fetch_misaligned;
`endif
  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );
  always #5 clk = ~clk;
  always_comb imem_rdata = (imem_addr == 32'hC) ? 32'h0050_0093 : (imem_addr ^ 32'h1234_0013);
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    chk("rst_misal", 32'(fetch_misaligned), 32'd0);
`endif
    rst = 1'b0;
    step();
    chk("f0_req", 32'(imem_req), 32'd1);
    chk("f0_addr", imem_addr, 32'h0);
    step();
    chk("v0_valid", 32'(instr_valid), 32'd1);
    chk("v0_req", 32'(imem_req), 32'd0);
    chk("v0_pc", instr_pc, 32'h0);
    chk("v0_instr", instr, 32'h1234_0013);
    step();
    chk("f4_addr", imem_addr, 32'h4);
    chk("f4_valid", 32'(instr_valid), 32'd0);
    step();
    chk("v4_pc", instr_pc, 32'h4);
    step();
    chk("f8_addr", imem_addr, 32'h8);
    step();
    chk("v8_pc", instr_pc, 32'h8);
    chk("v8_instr", instr, 32'h1234_001B);
    step();
    chk("fc_addr", imem_addr, 32'hC);
    step();
    chk("vc_pc", instr_pc, 32'hC);
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_instr", instr, 32'h0050_0093);
      chk("stall_pc", instr_pc, 32'hC);
    end
    instr_ready = 1'b1;
    step();
    chk("f10_addr", imem_addr, 32'h10);
    chk("f10_req", 32'(imem_req), 32'd1);
    step();
    chk("v10_pc", instr_pc, 32'h10);
    imem_ack = 1'b0;
    step();
    chk("f14_addr", imem_addr, 32'h14);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_req", 32'(imem_req), 32'd1);
      chk("drain_addr", imem_addr, 32'h14);
      chk("drain_valid", 32'(instr_valid), 32'd0);
      if (i < 2) step();
    end
    imem_ack = 1'b1;
    step();
    chk("f100_addr", imem_addr, 32'h100);
    chk("f100_valid", 32'(instr_valid), 32'd0);
    step();
    chk("v100_pc", instr_pc, 32'h100);
    chk("v100_instr", instr, 32'h1234_0113);
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("f40_addr", imem_addr, 32'h40);
    chk("f40_valid", 32'(instr_valid), 32'd0);
    step();
    chk("v40_pc", instr_pc, 32'h40);
    chk("v40_instr", instr, 32'h1234_0053);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("fwrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("vwrap_pc", instr_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_next_addr", imem_addr, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("ackredir_addr", imem_addr, 32'h200);
    chk("ackredir_req", 32'(imem_req), 32'd1);
    chk("ackredir_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    chk("drain2_addr", imem_addr, 32'h200);
    rst = 1'b1;
    #1;
    chk("rstmid_req", 32'(imem_req), 32'd0);
    chk("rstmid_valid", 32'(instr_valid), 32'd0);
    step();
    rst = 1'b0;
    imem_ack = 1'b1;
    step();
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    step();
    chk("post_rst_pc", instr_pc, 32'h0);
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("trap_misal", 32'(fetch_misaligned), 32'd1);
      chk("trap_req", 32'(imem_req), 32'd0);
      chk("trap_valid", 32'(instr_valid), 32'd0);
      step();
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
